// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2-flop synchronizer, mid-bit start validation and break hold-off.
// Defining UART_RX_PARITY_EN switches to 8E1 and adds the parity_err port.
module uart_rx #(
  parameter int BAUD_DIV = 5208,
  parameter int CNT_W    = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] dout,
  output logic       data_strb,
  output logic       busy,
  output logic       framing_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  state_t state_q, state_d;
  logic s1_q, s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sh_q, sh_d, dout_q, dout_d;
  logic strb_q, strb_d, ferr_q, ferr_d;
  logic rx_s, tick, half;
`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, perr_q, perr_d;
`endif
  assign rx_s = s2_q;
  assign tick = cnt_q == CNT_W'(BAUD_DIV - 1);
  assign half = cnt_q == CNT_W'(BAUD_DIV / 2 - 1);
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    dout_d  = dout_q;
    strb_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      IDLE:  state_d = rx_s ? IDLE : START;
      START: begin
        idx_d = 3'd0;
        if (half) state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (tick) begin
        sh_d  = {rx_s, sh_q[7:1]};
        idx_d = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
        if (idx_q == 3'd7) state_d = PARITY;
`else
        if (idx_q == 3'd7) state_d = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        par_d   = rx_s;
        state_d = STOP;
      end
`endif
      STOP: if (tick) begin
        state_d = rx_s ? IDLE : BREAK;
        dout_d  = rx_s ? sh_q : dout_q;
        strb_d  = rx_s;
        ferr_d  = !rx_s;
`ifdef UART_RX_PARITY_EN
        perr_d  = rx_s & (^{sh_q, par_q});
`endif
      end
      BREAK:   state_d = rx_s ? IDLE : BREAK;
      default: state_d = IDLE;
    endcase
    // timer restarts on every state entry and wraps each bit period
    cnt_d = (state_d != state_q || state_q == IDLE || tick) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      dout_q  <= '0;
      strb_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      s1_q    <= rx_in;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      strb_q  <= strb_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end
  assign dout        = dout_q;
  assign busy        = state_q != IDLE;
  assign data_strb   = strb_q & ~reset;
  assign framing_err = ferr_q & ~reset;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = perr_q & ~reset;
`endif
endmodule
